// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the and_8bit slice: default operand
//               width and the single-bit fill values the result flags are
//               built from (replicated to whatever width is in use).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width
    localparam int unsigned AND_WIDTH_DEFAULT = 8;

    // Fill bits; replicated to WIDTH to form the all-ones / zero constants
    localparam logic C_BIT_ONE  = 1'b1;
    localparam logic C_BIT_ZERO = 1'b0;

    // Registered flag pair
    typedef struct packed {
        logic zero;
        logic all_ones;
    } flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/and_8bit_if.sv
`default_nettype none
// ============================================================================
// Module      : and_8bit_if
// Description : Operand/result bundle for and_8bit.
//   A, B       : operands (master -> slave)
//   in_valid   : qualifies A/B for the registered path (master -> slave)
//   Y          : combinational A & B (slave -> master)
//   Y_q        : registered result (slave -> master)
//   out_valid  : Y_q captured on the previous edge (slave -> master)
//   zero       : registered flag, captured result == 0 (slave -> master)
//   all_ones   : registered flag, captured result all ones (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface and_8bit_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = AND_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_q;
    logic             out_valid;
    logic             zero;
    logic             all_ones;

    modport master (
        output A, B, in_valid,
        input  Y, Y_q, out_valid, zero, all_ones
    );

    modport slave (
        input  A, B, in_valid,
        output Y, Y_q, out_valid, zero, all_ones
    );
endinterface : and_8bit_if
`default_nettype wire

// File: rtl/and_8bit_result_flags.sv
`default_nettype none
// ============================================================================
// Module      : result_flags
// Description : Combinational zero / all-ones detection on a result word.
//   i_result   : word to classify
//   o_zero     : i_result == 0
//   o_all_ones : every bit of i_result set
// Revision    : 1.0 - initial release
// ============================================================================
module result_flags
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = AND_WIDTH_DEFAULT
) (
    input  wire logic [WIDTH-1:0] i_result,
    output logic                  o_zero,
    output logic                  o_all_ones
);
    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{C_BIT_ONE}};
    localparam logic [WIDTH-1:0] C_ZERO     = {WIDTH{C_BIT_ZERO}};

    // For WIDTH == 1 both compares still differ (0 vs 1), so the flags
    // remain mutually exclusive at every width.
    assign o_zero     = (i_result == C_ZERO);
    assign o_all_ones = (i_result == C_ALL_ONES);
endmodule : result_flags
`default_nettype wire

// File: rtl/and_8bit.sv
`default_nettype none
// ============================================================================
// Module      : and_8bit
// Description : Bitwise AND with a combinational output and a one-cycle
//               registered output carrying zero / all-ones flags.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : and_8bit_if slave (A, B, in_valid -> Y, Y_q, out_valid,
//                zero, all_ones)
// Revision    : 1.0 - initial release
// ============================================================================
module and_8bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = AND_WIDTH_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     rst,
    and_8bit_if.slave     bus
);
    logic [WIDTH-1:0] w_and;
    flags_t           w_flags;

    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    flags_t           r_flags;

    // Combinational path: independent of clk, rst and in_valid
    assign w_and = bus.A & bus.B;
    assign bus.Y = w_and;

    result_flags #(
        .WIDTH (WIDTH)
    ) u_result_flags (
        .i_result   (w_and),
        .o_zero     (w_flags.zero),
        .o_all_ones (w_flags.all_ones)
    );

    // Output register stage. Reset value matches a captured result of 0,
    // so zero is 1 out of reset. Reset beats a coincident in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q            <= '0;
            r_out_valid      <= 1'b0;
            r_flags.zero     <= 1'b1;
            r_flags.all_ones <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_y_q   <= w_and;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.Y_q       = r_y_q;
    assign bus.out_valid = r_out_valid;
    assign bus.zero      = r_flags.zero;
    assign bus.all_ones  = r_flags.all_ones;
endmodule : and_8bit
`default_nettype wire

// File: tb/tb_and_8bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_and_8bit
// Description : Self-checking bench for and_8bit: directed vectors followed
//               by a randomized sweep against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and_8bit;
    localparam int W = 8;
    localparam int ALL = (1 << W) - 1;

    logic clk;
    logic rst;

    and_8bit_if #(.WIDTH(W)) ifc ();

    and_8bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the last accepted result and whether the
    // previous edge accepted one.
    int m_yq  = 0;
    int m_ov  = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Apply inputs, check Y combinationally, clock once, update the model,
    // then check the registered outputs.
    task automatic step(input int a, input int b, input int v, input int r,
                        input string tag);
        ifc.A        = a[W-1:0];
        ifc.B        = b[W-1:0];
        ifc.in_valid = v[0];
        rst          = r[0];
        #1;
        chk({tag, ".Y"}, int'(ifc.Y), a & b & ALL);
        @(posedge clk);
        if (r != 0) begin
            m_yq = 0;
            m_ov = 0;
        end else begin
            m_ov = v;
            if (v != 0) m_yq = a & b & ALL;
        end
        #1;
        chk({tag, ".Y_q"},       int'(ifc.Y_q),       m_yq);
        chk({tag, ".out_valid"}, int'(ifc.out_valid), m_ov);
        chk({tag, ".zero"},      int'(ifc.zero),      (m_yq == 0)   ? 1 : 0);
        chk({tag, ".all_ones"},  int'(ifc.all_ones),  (m_yq == ALL) ? 1 : 0);
        chk({tag, ".excl"},      int'(ifc.zero & ifc.all_ones), 0);
    endtask

    initial begin
        int a, b, v, r;
        rst          = 1'b1;
        ifc.A        = '0;
        ifc.B        = '0;
        ifc.in_valid = 1'b0;

        // Combinational result with no clock edge involved
        ifc.A = 8'b11110000;
        ifc.B = 8'b10101010;
        #2;
        chk("comb_nocl", int'(ifc.Y), 8'b10100000);

        // Reset state
        step(0, 0, 0, 1, "reset");

        step(8'hFF, 8'h00, 1, 0, "ff_and_00");
        step(8'h0F, 8'hF0, 0, 0, "0f_f0_hold");
        step(8'h55, 8'h55, 1, 0, "55_55");
        step(8'hFF, 8'hFF, 1, 0, "ff_ff");
        step(8'h12, 8'h34, 0, 0, "ff_hold");
        step(8'h00, 8'hFF, 1, 0, "00_ff");
        // Reset with in_valid and all-ones operands: reset wins, Y unaffected
        step(8'hFF, 8'hFF, 1, 1, "rst_vs_valid");
        // First valid after reset
        step(8'hC3, 8'hF3, 1, 0, "post_rst");
        // Back-to-back valids
        step(8'hA5, 8'h5A, 1, 0, "b2b_0");
        step(8'h3C, 8'hFF, 1, 0, "b2b_1");

        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, ALL));
            b = int'($urandom_range(0, ALL));
            // Bias some cycles toward the boundary operands
            case ($urandom_range(0, 9))
                0: a = ALL;
                1: b = 0;
                2: begin a = ALL; b = ALL; end
                default: ;
            endcase
            v = int'($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 49) == 0);
            step(a, b, v, r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_and_8bit
`default_nettype wire
